// File: rtl/tmr_vote_monitor.sv
// Registered bitwise majority voter for a triplicated bus, with per-lane
// disagreement telemetry, persistence-based stuck-lane detection and a req/ack clear.
module tmr_vote_monitor #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned PERSIST = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [WIDTH-1:0] in_c,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             err_now,
  output logic             multi_err,
  output logic [2:0]       err_lane,
  output logic [2:0]       lane_stuck,
  output logic [CNT_W-1:0] err_cnt,
  input  logic             clr_req,
  output logic             clr_ack
);

  localparam logic [7:0] PERSIST_C = 8'(PERSIST);

  typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_ACK} state_e;

  state_e state_q, state_d;
  logic   clr_phase;

  logic             valid_q;
  logic [WIDTH-1:0] data_q, data_d;
  logic             err_now_q;
  logic             multi_q, multi_d;
  logic [2:0]       lane_q, lane_d;
  logic [2:0]       stuck_q, stuck_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_base;
  logic [7:0]       pcnt_q [3];
  logic [7:0]       pcnt_d [3];
  logic [7:0]       pbase  [3];
  logic [2:0]       stuck_set;

  logic [WIDTH-1:0] maj;
  logic [2:0]       wrong;
  logic             beat_err, beat_multi;

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (clr_req) state_d = S_CLEAR;
      S_CLEAR: state_d = S_ACK;
      S_ACK:   if (!clr_req) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    clr_ack   = (state_q == S_ACK);
    clr_phase = (state_q == S_CLEAR);
  end

  always_comb begin
    maj        = (in_a & in_b) | (in_a & in_c) | (in_b & in_c);
    wrong[0]   = |(in_a ^ maj);
    wrong[1]   = |(in_b ^ maj);
    wrong[2]   = |(in_c ^ maj);
    beat_err   = in_valid & (|wrong);
    beat_multi = in_valid & ((wrong[0] & wrong[1]) | (wrong[0] & wrong[2]) |
                             (wrong[1] & wrong[2]));
  end

  // In the CLEAR cycle every accumulator starts from zero, so only this
  // cycle's beat contributes to the loaded value.
  always_comb begin
    data_d   = in_valid ? maj : data_q;
    cnt_base = clr_phase ? '0 : cnt_q;
    cnt_d    = cnt_base;
    if (beat_err && (cnt_base != '1)) cnt_d = cnt_base + CNT_W'(1);
    lane_d   = (clr_phase ? 3'b000 : lane_q) | (in_valid ? wrong : 3'b000);
    multi_d  = (clr_phase ? 1'b0 : multi_q) | beat_multi;

    stuck_set = '0;
    for (int unsigned i = 0; i < 3; i++) begin
      pbase[i]  = clr_phase ? 8'd0 : pcnt_q[i];
      pcnt_d[i] = pbase[i];
      if (in_valid) begin
        if (wrong[i]) begin
          if (pbase[i] != PERSIST_C) begin
            pcnt_d[i] = pbase[i] + 8'd1;
            if ((pbase[i] + 8'd1) == PERSIST_C) stuck_set[i] = 1'b1;
          end
        end else begin
          pcnt_d[i] = 8'd0;
        end
      end
    end
    stuck_d = (clr_phase ? 3'b000 : stuck_q) | stuck_set;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q   <= 1'b0;
      data_q    <= '0;
      err_now_q <= 1'b0;
      multi_q   <= 1'b0;
      lane_q    <= '0;
      stuck_q   <= '0;
      cnt_q     <= '0;
      pcnt_q    <= '{default: '0};
    end else begin
      valid_q   <= in_valid;
      data_q    <= data_d;
      err_now_q <= beat_err;
      multi_q   <= multi_d;
      lane_q    <= lane_d;
      stuck_q   <= stuck_d;
      cnt_q     <= cnt_d;
      pcnt_q    <= pcnt_d;
    end
  end

  assign out_valid  = valid_q;
  assign out_data   = data_q;
  assign err_now    = err_now_q;
  assign multi_err  = multi_q;
  assign err_lane   = lane_q;
  assign lane_stuck = stuck_q;
  assign err_cnt    = cnt_q;

endmodule

// File: tb/tb_tmr_vote_monitor.sv
// Scoreboard bench for tmr_vote_monitor: two instances (16-bit and 2-bit counters)
// share stimulus; a behavioural model pushes expectations, a monitor pops and compares.
module tb_tmr_vote_monitor;

  localparam int P = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] in_a = '0, in_b = '0, in_c = '0;
  logic       clr_req = 1'b0;

  logic        ov1, en1, me1, ack1, ov2, en2, me2, ack2;
  logic [7:0]  od1, od2;
  logic [2:0]  el1, ls1, el2, ls2;
  logic [15:0] c1;
  logic [1:0]  c2;

  tmr_vote_monitor #(.WIDTH(8), .CNT_W(16), .PERSIST(P)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_a(in_a), .in_b(in_b), .in_c(in_c),
    .out_valid(ov1), .out_data(od1), .err_now(en1), .multi_err(me1), .err_lane(el1),
    .lane_stuck(ls1), .err_cnt(c1), .clr_req(clr_req), .clr_ack(ack1));

  tmr_vote_monitor #(.WIDTH(8), .CNT_W(2), .PERSIST(P)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_a(in_a), .in_b(in_b), .in_c(in_c),
    .out_valid(ov2), .out_data(od2), .err_now(en2), .multi_err(me2), .err_lane(el2),
    .lane_stuck(ls2), .err_cnt(c2), .clr_req(clr_req), .clr_ack(ack2));

  always #5 clk = ~clk;

  typedef struct {
    logic v; logic [7:0] d; logic en; logic me;
    logic [2:0] el; logic [2:0] ls; logic [15:0] c16; logic [1:0] c2; logic ack;
  } exp_t;

  exp_t sb[$];
  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  logic       m_v, m_en, m_me, m_ack;
  logic [7:0] m_d;
  logic [2:0] m_el, m_ls;
  int         m_c16, m_c2;
  int         m_pc[3];
  int         m_phase;   // 0 idle, 1 clearing, 2 acknowledged

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_step(input logic r, input logic v, input logic [7:0] a,
                            input logic [7:0] b, input logic [7:0] c, input logic cr);
    logic [7:0] maj;
    logic [7:0] ln[3];
    logic [2:0] wr;
    int nw;
    if (r) begin
      m_v = 0; m_d = 0; m_en = 0; m_me = 0; m_el = 0; m_ls = 0;
      m_c16 = 0; m_c2 = 0; m_pc = '{0, 0, 0}; m_phase = 0;
    end else begin
      ln[0] = a; ln[1] = b; ln[2] = c;
      for (int i = 0; i < 8; i++)
        maj[i] = ((int'(a[i]) + int'(b[i]) + int'(c[i])) >= 2);
      nw = 0;
      for (int x = 0; x < 3; x++) begin
        wr[x] = (ln[x] != maj);
        nw += int'(wr[x]);
      end
      if (m_phase == 1) begin
        m_c16 = 0; m_c2 = 0; m_el = 0; m_me = 0; m_ls = 0; m_pc = '{0, 0, 0};
      end
      m_v  = v;
      m_en = 0;
      if (v) begin
        m_d = maj;
        if (nw > 0) begin
          m_en = 1;
          if (m_c16 < 65535) m_c16++;
          if (m_c2 < 3) m_c2++;
        end
        m_el |= wr;
        if (nw >= 2) m_me = 1;
        for (int x = 0; x < 3; x++) begin
          if (wr[x]) begin
            if (m_pc[x] < P) begin
              m_pc[x]++;
              if (m_pc[x] == P) m_ls[x] = 1;
            end
          end else m_pc[x] = 0;
        end
      end
      if (m_phase == 0)      m_phase = cr ? 1 : 0;
      else if (m_phase == 1) m_phase = 2;
      else                   m_phase = cr ? 2 : 0;
    end
    m_ack = (m_phase == 2);
  endtask

  task automatic drive(input logic r, input logic v, input logic [7:0] a,
                       input logic [7:0] b, input logic [7:0] c, input logic cr);
    exp_t e;
    @(negedge clk);
    rst = r; in_valid = v; in_a = a; in_b = b; in_c = c; clr_req = cr;
    model_step(r, v, a, b, c, cr);
    e.v = m_v; e.d = m_d; e.en = m_en; e.me = m_me; e.el = m_el; e.ls = m_ls;
    e.c16 = 16'(m_c16); e.c2 = 2'(m_c2); e.ack = m_ack;
    sb.push_back(e);
  endtask

  task automatic idle(input logic cr);
    drive(1'b0, 1'b0, 8'h00, 8'h00, 8'h00, cr);
  endtask

  task automatic beat(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                      input logic cr);
    drive(1'b0, 1'b1, a, b, c, cr);
  endtask

  task automatic do_reset();
    drive(1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
  endtask

  // Monitor: one expectation per driven cycle, compared just after the edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("out_valid",  32'(ov1),  32'(e.v));
        chk("out_data",   32'(od1),  32'(e.d));
        chk("err_now",    32'(en1),  32'(e.en));
        chk("multi_err",  32'(me1),  32'(e.me));
        chk("err_lane",   32'(el1),  32'(e.el));
        chk("lane_stuck", 32'(ls1),  32'(e.ls));
        chk("err_cnt",    32'(c1),   32'(e.c16));
        chk("clr_ack",    32'(ack1), 32'(e.ack));
        chk("w2_err_cnt", 32'(c2),   32'(e.c2));
        chk("w2_flags",   {16'd0, ov2, od2, en2, me2, el2, ls2, ack2},
                          {16'd0, e.v, e.d, e.en, e.me, e.el, e.ls, e.ack});
      end
    end
  end

  initial begin
    logic [7:0] base, a, b, c;
    logic cr, v, r;
    cr = 0;

    do_reset(); do_reset();
    chk("reset_cnt", 32'(c1), 32'd0);
    repeat (3) beat(8'h5A, 8'h5A, 8'h5A, 1'b0);
    idle(1'b0);
    chk("agree_data", 32'(od1), 32'h5A);
    chk("agree_cnt",  32'(c1),  32'd0);

    beat(8'h5A, 8'h5B, 8'h5A, 1'b0);
    idle(1'b0);
    chk("single_err_now",  32'(en1), 32'd1);
    chk("single_err_lane", 32'(el1), 32'b010);
    chk("single_err_cnt",  32'(c1),  32'd1);
    chk("single_multi",    32'(me1), 32'd0);

    do_reset();
    repeat (4) beat(8'h01, 8'h00, 8'h00, 1'b0);
    idle(1'b0);
    chk("stuck_4beats", 32'(ls1), 32'b001);
    chk("stuck_cnt",    32'(c1),  32'd4);

    do_reset();
    repeat (2) beat(8'h01, 8'h00, 8'h00, 1'b0);
    idle(1'b0);
    repeat (2) beat(8'h01, 8'h00, 8'h00, 1'b0);
    idle(1'b0);
    chk("stuck_gap", 32'(ls1), 32'b001);

    do_reset();
    repeat (2) beat(8'h01, 8'h00, 8'h00, 1'b0);
    beat(8'h00, 8'h00, 8'h00, 1'b0);
    repeat (2) beat(8'h01, 8'h00, 8'h00, 1'b0);
    idle(1'b0);
    chk("stuck_broken", 32'(ls1), 32'b000);

    do_reset();
    beat(8'h01, 8'h02, 8'h00, 1'b0);
    idle(1'b0);
    chk("multi_err",  32'(me1), 32'd1);
    chk("multi_lane", 32'(el1), 32'b011);
    repeat (4) beat(8'h01, 8'h02, 8'h00, 1'b0);
    idle(1'b0);
    chk("sat_cnt2",  32'(c2), 32'd3);
    chk("cnt16_5",   32'(c1), 32'd5);

    // clear with an erroring beat landing exactly in the CLEAR cycle
    idle(1'b1);
    beat(8'h00, 8'h00, 8'h80, 1'b1);
    idle(1'b1);
    chk("clear_cnt2", 32'(c2),   32'd1);
    chk("clear_ack",  32'(ack1), 32'd1);
    chk("clear_lane", 32'(el1),  32'b100);
    idle(1'b0);
    idle(1'b0);
    chk("ack_drop", 32'(ack1), 32'd0);

    // reset during ACK with flags set
    idle(1'b1); idle(1'b1);
    beat(8'hFF, 8'h00, 8'h00, 1'b1);
    drive(1'b1, 1'b1, 8'hFF, 8'h00, 8'h00, 1'b1);
    idle(1'b0);
    chk("rst_ack_all", {ov1, od1, en1, me1, el1, ls1, ack1, c1}, '0);
    idle(1'b1); idle(1'b1); idle(1'b1);
    chk("reclear_ack", 32'(ack1), 32'd1);
    idle(1'b0); idle(1'b0);

    // randomized traffic
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 19) == 0) cr = ~cr;
      r = ($urandom_range(0, 99) == 0);
      v = ($urandom_range(0, 3) != 0);
      base = 8'($urandom);
      a = base; b = base; c = base;
      if ($urandom_range(0, 3) == 0) a = base ^ 8'($urandom_range(1, 255));
      if ($urandom_range(0, 5) == 0) b = base ^ 8'($urandom_range(1, 255));
      if ($urandom_range(0, 7) == 0) c = base ^ 8'($urandom_range(1, 255));
      if ($urandom_range(0, 9) == 0) begin a = 8'($urandom); b = 8'($urandom); c = 8'($urandom); end
      drive(r, v, a, b, c, cr);
    end
    idle(1'b0); idle(1'b0);

    for (int k = 0; k < 20 && sb.size() > 0; k++) @(posedge clk);
    #2;
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/tmr_vote_monitor.md
# tmr_vote_monitor

Registered majority voter and fault monitor that consumes the three copies of a triplicated bus (e.g. the A/B/C outputs of a triplicated gate or register stage) and produces a single corrected bus plus error telemetry. It sits directly downstream of triplicated logic, at the boundary where a triplicated domain feeds non-triplicated logic. It counts corrected beats, tracks which lanes disagreed, and detects persistently failing lanes. Software clears the telemetry through a request/acknowledge handshake.

## Interface
- WIDTH, 8, width of each voted copy (≥1)
- CNT_W, 16, width of saturating error counter (≥2)
- PERSIST, 4, consecutive disagreeing valid beats that mark a lane stuck (≥2, fits in 8 bits)

- clk  input  1  single clock, all state on rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  in_a/in_b/in_c carry a beat this cycle
- in_a, in_b, in_c  input  WIDTH  three copies of the triplicated bus
- out_valid  output  1  registered in_valid
- out_data  output  WIDTH  registered bitwise majority of in_a/in_b/in_c
- err_now  output  1  registered: previous valid beat had at least one disagreeing bit
- multi_err  output  1  sticky: some valid beat had ≥2 lanes each wrong on some bit
- err_lane  output  3  sticky per lane [0]=a [1]=b [2]=c: lane disagreed with majority
- lane_stuck  output  3  sticky per lane: PERSIST consecutive disagreeing valid beats
- err_cnt  output  CNT_W  saturating count of valid beats with err_now condition
- clr_req  input  1  level request to clear telemetry
- clr_ack  output  1  clear complete; held until clr_req drops

## Operation
- Majority per bit: maj = (a&b)|(a&c)|(b&c). Lane x is wrong on a beat if (x ^ maj) != 0.
- beat_err = in_valid & (any lane wrong). beat_multi = in_valid & (≥2 lanes wrong). Both are zero when in_valid = 0.
- When in_valid = 0, out_data holds its previous value, err_now = 0, and persistence counters hold.
- err_cnt increments on each beat_err. It saturates at 2^CNT_W−1 with no wrap.
- err_lane[x] |= lane x wrong on a valid beat. multi_err |= beat_multi.
- Persistence counter per lane (8 bits):
  - On a valid beat where the lane is wrong, increment, saturating at PERSIST.
  - On a valid beat where the lane is right, reset to 0.
  - lane_stuck[x] sets on the beat whose increment makes the counter reach PERSIST.
- Clear FSM states:
  - IDLE: clr_ack = 0. clr_req = 1 → CLEAR.
  - CLEAR, one cycle: err_cnt, err_lane, multi_err, lane_stuck and persistence counters are loaded with this cycle's contribution only. For example, a beat_err in the CLEAR cycle gives err_cnt = 1. Next state is ACK.
  - ACK: clr_ack = 1. Stays in ACK while clr_req = 1. clr_req = 0 → IDLE.
  - Telemetry keeps accumulating normally in ACK and IDLE.
- Reset, including reset asserted mid-handshake or mid-beat: every output and counter goes to 0 and the FSM goes to IDLE. out_data resets to 0.

## Timing
- Latency: 1 cycle. Inputs sampled at edge N appear on out_data/out_valid/err_now after edge N.
- Sticky flags and err_cnt update on the same edge as out_data, so they are visible together with the beat that caused them.
- Clear handshake: clr_req rising, sampled at edge N → CLEAR during cycle N+1 → clr_ack = 1 after edge N+1. Cleared values are visible after edge N+1.
- clr_ack falls one cycle after clr_req is sampled low. A new request needs clr_req low for at least one cycle in IDLE.
- Full throughput: in_valid may be 1 every cycle. There is no backpressure.

## Test plan
- WIDTH=8. Reset, then a=b=c=8'h5A valid for 3 cycles → out_data=8'h5A one cycle later, err_now=0, err_cnt=0, all flags 0.
- a=8'h5A, b=8'h5B, c=8'h5A, one valid beat → out_data=8'h5A, err_now=1 for one cycle, err_lane=3'b010, err_cnt=1, multi_err=0.
- a=8'h01, b=8'h00, c=8'h00 for four consecutive valid beats with PERSIST=4 → lane_stuck[0] sets after the 4th beat, err_cnt=4. Repeat with an invalid cycle between beats 2 and 3 → still set after the 4th valid beat. Repeat with an agreeing beat after beat 2 → not set.
- a=8'h01, b=8'h02, c=8'h00 (majority 8'h00) → multi_err=1, err_lane=3'b011. CNT_W=2 with 5 erroring beats → err_cnt stays at 3.
- With err_cnt=3, raise clr_req and hold it; inject an erroring beat exactly in the CLEAR cycle → err_cnt=1 and clr_ack=1 one cycle after the CLEAR cycle. Drop clr_req → clr_ack=0 one cycle later.
- Assert rst during ACK with flags set → all outputs 0 next cycle, FSM returns to IDLE, and a new clr_req completes normally.
